// File: rtl/systolic_feeder_if.sv
// Handshake and array-facing bundle for systolic_feeder: weight rows in, activation
// vectors in, skewed lanes / weight image / control strobes out to the array.
interface systolic_feeder_if #(
  parameter int LANES = 9,
  parameter int WIDTH = 8
);
  logic                           W_Valid;
  logic [LANES*WIDTH-1:0]         W_Data;
  logic                           W_Ready;
  logic                           X_Valid;
  logic [LANES*WIDTH-1:0]         X_Data;
  logic                           X_Last;
  logic                           X_Ready;
  logic [LANES*WIDTH-1:0]         A;
  logic [LANES*LANES*WIDTH-1:0]   Mem_In;
  logic                           Ld;
  logic                           Arr_Clr;
  logic                           Res_Valid;
  logic                           Busy;

  modport master (
    output W_Valid, W_Data, X_Valid, X_Data, X_Last,
    input  W_Ready, X_Ready, A, Mem_In, Ld, Arr_Clr, Res_Valid, Busy
  );

  modport slave (
    input  W_Valid, W_Data, X_Valid, X_Data, X_Last,
    output W_Ready, X_Ready, A, Mem_In, Ld, Arr_Clr, Res_Valid, Busy
  );
endinterface

// File: rtl/systolic_feeder.sv
// Loads a LANES x LANES weight image into a shadow register, commits it to the array,
// then streams activation vectors with a per-lane skew of lane+1 cycles.
module systolic_feeder #(
  parameter int LANES = 9,
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  systolic_feeder_if.slave bus
);

  localparam int ROW_W = LANES * WIDTH;
  localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW    = $clog2(LANES + 1);

  localparam logic [BW-1:0] LAST_BEAT  = BW'(LANES - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(LANES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [BW-1:0] r_beat;
  logic [DW-1:0] r_drain;
  logic [LANES:0] r_tag;
  logic          w_beat;
  logic          w_accept;

  assign w_beat   = (r_state == S_LOAD)   && bus.W_Valid;
  assign w_accept = (r_state == S_STREAM) && bus.X_Valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.W_Valid) w_state_next = S_LOAD;
      S_LOAD:   if (w_beat && (r_beat == LAST_BEAT)) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_STREAM;
      S_STREAM: if (w_accept && bus.X_Last) w_state_next = S_DRAIN;
      S_DRAIN:  if (r_drain == LAST_DRAIN) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // The drain counter spans LANES+1 cycles so the last Res_Valid tag lands inside DRAIN.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_drain <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_beat) r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BW'(1);
      r_drain <= (r_state == S_DRAIN) ? r_drain + DW'(1) : '0;
      r_tag   <= {r_tag[LANES-1:0], w_accept};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_row
      logic [ROW_W-1:0] r_row;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_row <= '0;
        end else if (w_beat && (r_beat == BW'(gi))) begin
          r_row <= bus.W_Data;
        end
      end

      assign bus.Mem_In[gi*ROW_W +: ROW_W] = r_row;
    end

    // Lane gi sits behind gi+1 stages; idle cycles push zeros so gaps stay clean.
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WIDTH-1:0] r_pipe [gi+1];

      always_ff @(posedge Clk) begin
        if (Rst) begin
          for (int j = 0; j <= gi; j++) r_pipe[j] <= '0;
        end else begin
          r_pipe[0] <= w_accept ? bus.X_Data[gi*WIDTH +: WIDTH] : '0;
          for (int j = 1; j <= gi; j++) r_pipe[j] <= r_pipe[j-1];
        end
      end

      assign bus.A[gi*WIDTH +: WIDTH] = r_pipe[gi];
    end
  endgenerate

  assign bus.W_Ready   = (r_state == S_LOAD);
  assign bus.X_Ready   = (r_state == S_STREAM);
  assign bus.Ld        = (r_state == S_COMMIT);
  assign bus.Busy      = (r_state != S_IDLE);
  assign bus.Res_Valid = r_tag[LANES];
  assign bus.Arr_Clr   = Rst || ((r_state == S_IDLE) && bus.W_Valid);

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: random weight loads and activation streams
// compared against a cycle-indexed model of accepted vectors.
module tb_systolic_feeder;
  localparam int LANES = 9;
  localparam int WIDTH = 8;
  localparam int LW    = LANES * WIDTH;
  localparam int MW    = LANES * LW;
  localparam int CMAX  = 4096;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  systolic_feeder_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();
  systolic_feeder #(.LANES(LANES), .WIDTH(WIDTH)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int floor_c = 0;
  bit in_stream = 1'b0;
  bit acc_v [CMAX];
  logic [LW-1:0] acc_d [CMAX];
  logic [MW-1:0] exp_mem = '0;

  // Expected A: lane i carries whatever vector was accepted i+1 cycles earlier, else zero.
  function automatic logic [LW-1:0] exp_a(input int c);
    logic [LW-1:0] r = '0;
    for (int i = 0; i < LANES; i++) begin
      int s = c - i - 1;
      if (s >= floor_c && s >= 0 && acc_v[s % CMAX])
        r[i*WIDTH +: WIDTH] = acc_d[s % CMAX][i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic exp_rv(input int c);
    int s = c - LANES - 1;
    return (s >= floor_c && s >= 0) ? acc_v[s % CMAX] : 1'b0;
  endfunction

  function automatic logic [LW-1:0] rand_row();
    logic [LW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  // One clock cycle: drive inputs just after the edge, return at the falling edge.
  task automatic step(input logic rst, input logic wv, input logic [LW-1:0] wd,
                      input logic xv, input logic xl, input logic [LW-1:0] xd);
    @(posedge Clk); #1;
    cyc++;
    Rst = rst;
    bus.W_Valid = wv; bus.W_Data = wd;
    bus.X_Valid = xv; bus.X_Last = xl; bus.X_Data = xd;
    acc_v[cyc % CMAX] = xv && in_stream && !rst;
    acc_d[cyc % CMAX] = xd;
    if (rst) floor_c = cyc + 1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      tests++;
      if (bus.Arr_Clr !== 1'b1) begin fails++; $display("FAIL reset_arr_clr got=%b want=1", bus.Arr_Clr); end
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tests++; if (bus.A !== '0) begin fails++; $display("FAIL reset_a got=%h want=0", bus.A); end
    tests++; if (bus.Mem_In !== '0) begin fails++; $display("FAIL reset_mem_in got=%h want=0", bus.Mem_In); end
    tests++; if (bus.Ld !== 1'b0) begin fails++; $display("FAIL reset_ld got=%b want=0", bus.Ld); end
    tests++; if (bus.Arr_Clr !== 1'b0) begin fails++; $display("FAIL reset_arr_clr_after got=%b want=0", bus.Arr_Clr); end
    tests++; if (bus.Res_Valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got=%b want=0", bus.Res_Valid); end
    tests++; if (bus.W_Ready !== 1'b0) begin fails++; $display("FAIL reset_w_ready got=%b want=0", bus.W_Ready); end
    tests++; if (bus.X_Ready !== 1'b0) begin fails++; $display("FAIL reset_x_ready got=%b want=0", bus.X_Ready); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
    $display("[TB] reset done cyc=%0d", cyc);
  endtask

  // Loads a full weight image; leaves the DUT in STREAM after one idle stream cycle.
  task automatic test_load(input bit patterned, input bit gaps);
    logic [LW-1:0] rows [LANES];
    int k = 0;
    for (int r = 0; r < LANES; r++) begin
      if (patterned) for (int i = 0; i < LANES; i++) rows[r][i*WIDTH +: WIDTH] = WIDTH'(r + 1);
      else rows[r] = rand_row();
    end
    step(1'b0, 1'b1, rand_row(), 1'b0, 1'b0, '0);
    tests++; if (bus.Arr_Clr !== 1'b1) begin fails++; $display("FAIL load_arr_clr got=%b want=1", bus.Arr_Clr); end
    tests++; if (bus.W_Ready !== 1'b0) begin fails++; $display("FAIL load_idle_w_ready got=%b want=0", bus.W_Ready); end
    while (k < LANES) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        step(1'b0, 1'b0, rand_row(), 1'b0, 1'b0, '0);
      end else begin
        step(1'b0, 1'b1, rows[k], 1'b0, 1'b0, '0);
        k++;
      end
      tests++; if (bus.W_Ready !== 1'b1) begin fails++; $display("FAIL load_w_ready cyc=%0d got=%b want=1", cyc, bus.W_Ready); end
      tests++; if (bus.Ld !== 1'b0) begin fails++; $display("FAIL load_ld_early cyc=%0d got=%b want=0", cyc, bus.Ld); end
    end
    for (int r = 0; r < LANES; r++) exp_mem[r*LW +: LW] = rows[r];
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tests++; if (bus.Ld !== 1'b1) begin fails++; $display("FAIL commit_ld got=%b want=1", bus.Ld); end
    tests++; if (bus.X_Ready !== 1'b0) begin fails++; $display("FAIL commit_x_ready got=%b want=0", bus.X_Ready); end
    tests++; if (bus.Mem_In !== exp_mem) begin fails++; $display("FAIL commit_mem_in got=%h want=%h", bus.Mem_In, exp_mem); end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tests++; if (bus.Ld !== 1'b0) begin fails++; $display("FAIL stream_ld got=%b want=0", bus.Ld); end
    tests++; if (bus.X_Ready !== 1'b1) begin fails++; $display("FAIL stream_x_ready got=%b want=1", bus.X_Ready); end
    in_stream = 1'b1;
    $display("[TB] load committed cyc=%0d patterned=%0d gaps=%0d", cyc, patterned, gaps);
  endtask

  // gap < 0 picks a random bubble count (0..3) between vectors.
  task automatic run_stream(input int n, input bit fixed02, input int gap, input bit wnoise);
    bit xv_q[$]; bit xl_q[$]; bit busy_q[$]; logic [LW-1:0] xd_q[$];
    logic [LW-1:0] d;
    int pulses = 0;
    for (int v = 0; v < n; v++) begin
      int g = (v == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      for (int b = 0; b < g; b++) begin xv_q.push_back(1'b0); xl_q.push_back(1'b0); xd_q.push_back(rand_row()); busy_q.push_back(1'b1); end
      if (fixed02) for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = WIDTH'(2);
      else d = rand_row();
      xv_q.push_back(1'b1); xl_q.push_back(v == n - 1); xd_q.push_back(d); busy_q.push_back(1'b1);
    end
    for (int b = 0; b <= LANES; b++) begin xv_q.push_back(1'b0); xl_q.push_back(1'b0); xd_q.push_back('0); busy_q.push_back(1'b1); end
    xv_q.push_back(1'b0); xl_q.push_back(1'b0); xd_q.push_back('0); busy_q.push_back(1'b0);
    for (int idx = 0; idx < xv_q.size(); idx++) begin
      logic exp_xr = in_stream;
      step(1'b0, wnoise && in_stream, rand_row(), xv_q[idx], xl_q[idx], xd_q[idx]);
      if (xv_q[idx] && exp_xr) $display("[TB] vector accepted cyc=%0d last=%0d data=%h", cyc, xl_q[idx], xd_q[idx]);
      if (xv_q[idx] && xl_q[idx] && exp_xr) in_stream = 1'b0;
      if (bus.Res_Valid === 1'b1) pulses++;
      tests++; if (bus.A !== exp_a(cyc)) begin fails++; $display("FAIL stream_a cyc=%0d got=%h want=%h", cyc, bus.A, exp_a(cyc)); end
      tests++; if (bus.Res_Valid !== exp_rv(cyc)) begin fails++; $display("FAIL stream_res_valid cyc=%0d got=%b want=%b", cyc, bus.Res_Valid, exp_rv(cyc)); end
      tests++; if (bus.X_Ready !== exp_xr) begin fails++; $display("FAIL stream_x_ready cyc=%0d got=%b want=%b", cyc, bus.X_Ready, exp_xr); end
      tests++; if (bus.Busy !== busy_q[idx]) begin fails++; $display("FAIL stream_busy cyc=%0d got=%b want=%b", cyc, bus.Busy, busy_q[idx]); end
      tests++; if (bus.Ld !== 1'b0 || bus.W_Ready !== 1'b0) begin fails++; $display("FAIL stream_ld_w_ready cyc=%0d got=%b%b want=00", cyc, bus.Ld, bus.W_Ready); end
      tests++; if (bus.Mem_In !== exp_mem) begin fails++; $display("FAIL stream_mem_in cyc=%0d got=%h want=%h", cyc, bus.Mem_In, exp_mem); end
    end
    tests++; if (pulses != n) begin fails++; $display("FAIL stream_pulse_count got=%0d want=%0d", pulses, n); end
  endtask

  task automatic test_stream_single();   run_stream(1, 1'b1, 0, 1'b0);  endtask
  task automatic test_bubbles();         run_stream(3, 1'b0, 1, 1'b0);  endtask
  task automatic test_back_to_back();    run_stream(5, 1'b0, 0, 1'b0);  endtask
  task automatic test_random_stream();   run_stream(6, 1'b0, -1, 1'b0); endtask
  task automatic test_w_during_stream(); run_stream(4, 1'b0, -1, 1'b1); endtask

  task automatic test_reset_drain();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, rand_row());
    in_stream = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      tests++; if (bus.A !== exp_a(cyc)) begin fails++; $display("FAIL drain_a cyc=%0d got=%h want=%h", cyc, bus.A, exp_a(cyc)); end
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL rst_drain_busy got=%b want=0", bus.Busy); end
    tests++; if (bus.A !== '0) begin fails++; $display("FAIL rst_drain_a got=%h want=0", bus.A); end
    for (int i = 0; i < LANES + 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      tests++; if (bus.Res_Valid !== 1'b0) begin fails++; $display("FAIL rst_drain_res_valid cyc=%0d got=%b want=0", cyc, bus.Res_Valid); end
    end
    $display("[TB] reset during drain done cyc=%0d", cyc);
  endtask

  initial begin
    bus.W_Valid = 1'b0; bus.W_Data = '0;
    bus.X_Valid = 1'b0; bus.X_Last = 1'b0; bus.X_Data = '0;
    for (int i = 0; i < CMAX; i++) begin acc_v[i] = 1'b0; acc_d[i] = '0; end
    test_reset();
    test_load(1'b1, 1'b0);
    test_stream_single();
    test_load(1'b0, 1'b1);
    test_bubbles();
    test_load(1'b0, 1'b0);
    test_back_to_back();
    test_load(1'b0, 1'b1);
    test_random_stream();
    test_load(1'b0, 1'b0);
    test_w_during_stream();
    test_load(1'b0, 1'b1);
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
